// File: rtl/trng_conditioner.sv
// TRNG post-processing: Von Neumann debiasing, repetition-count health test,
// word packing and a small output FIFO with a valid/ready interface.
//
// state    | meaning
// ---------+------------------------------------------------
// P_FIRST  | waiting for the first bit of a raw pair (b0)
// P_SECOND | b0 held, next raw bit decides what is emitted
module trng_conditioner #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RC_CUTOFF  = 32
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic                             raw_bit,
  input  logic                             raw_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             overflow,
  output logic                             health_fail,
  input  logic                             clear_fail
);

  localparam int CW = $clog2(DATA_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]    RC_MAX   = 8'(RC_CUTOFF);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {P_FIRST = 1'b0, P_SECOND = 1'b1} pair_t;

  pair_t             state, state_nx;
  logic              b0;
  logic              emit, emit_bit;
  logic [7:0]        rc_cnt, rc_next;
  logic              last_bit;
  logic              trip, sample;
  logic [DATA_W-2:0] acc;
  logic [DATA_W-1:0] acc_sh;
  logic [CW-1:0]     bit_cnt;
  logic              word_done;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              full, pop, push_ok, flush;

  // Repetition count; the tripping sample itself never reaches the pair FSM.
  always_comb begin
    rc_next = rc_cnt;
    if (rc_cnt == 8'd0 || raw_bit != last_bit) rc_next = 8'd1;
    else if (rc_cnt != RC_MAX)                 rc_next = rc_cnt + 8'd1;
  end

  assign trip   = raw_valid && !health_fail && (rc_next == RC_MAX);
  assign sample = raw_valid && !health_fail && !trip;
  assign flush  = trip || health_fail;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      health_fail <= 1'b0;
      rc_cnt      <= 8'd0;
      last_bit    <= 1'b0;
    end else if (health_fail) begin
      if (clear_fail) begin
        health_fail <= 1'b0;
        rc_cnt      <= 8'd0;
      end
    end else if (raw_valid) begin
      rc_cnt      <= rc_next;
      last_bit    <= raw_bit;
      health_fail <= trip;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= P_FIRST;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush)          state_nx = P_FIRST;
    else if (raw_valid) state_nx = (state == P_FIRST) ? P_SECOND : P_FIRST;
  end

  always_comb begin
    emit     = 1'b0;
    emit_bit = 1'b0;
    if (sample && state == P_SECOND && raw_bit != b0) begin
      emit     = 1'b1;
      emit_bit = b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                         b0 <= 1'b0;
    else if (sample && state == P_FIRST) b0 <= raw_bit;
  end

  // Only DATA_W-1 bits are stored; the last bit goes straight into the pushed word.
  assign acc_sh    = {acc, emit_bit};
  assign word_done = emit && (bit_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (flush) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (emit) begin
      acc     <= acc_sh[DATA_W-2:0];
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  assign full      = (fifo_level == FULL_LVL);
  assign out_valid = (fifo_level != '0) && !health_fail;
  assign pop       = out_valid && out_ready;
  assign push_ok   = word_done && (!full || pop);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= acc_sh;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= word_done && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_conditioner.sv
// Bench for trng_conditioner: vector table plus hand-written corner sequences,
// output words checked against a queue of expected words.
module tb_trng_conditioner;
  logic       clk = 1'b0;
  logic       n_reset, raw_bit, raw_valid, out_ready, clear_fail;
  logic [7:0] out_data;
  logic       out_valid, overflow, health_fail;
  logic [2:0] fifo_level;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] raw;
    logic        gap;
    logic        has_word;
    logic [7:0]  word;
  } vec_t;
  vec_t vecs[6];

  trng_conditioner dut (
    .clk(clk), .n_reset(n_reset), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow), .health_fail(health_fail),
    .clear_fail(clear_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: handshake monitor at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL word_unexpected actual=%0h required=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("word", 32'(out_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] r, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive_bit(r[i]);
  endtask

  function automatic logic [15:0] enc(input logic [7:0] w);
    logic [15:0] r;
    for (int i = 7; i >= 0; i--) r[2*i+1 -: 2] = w[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    repeat (2) tick();
    chk(name, 32'(exp_q.size()), 0);
    chk({name, "_level"}, 32'(fifo_level), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r;
    vecs[0] = '{raw: 16'h6666, gap: 1'b0, has_word: 1'b1, word: 8'h55};
    vecs[1] = '{raw: 16'h3333, gap: 1'b0, has_word: 1'b0, word: 8'h00};
    vecs[2] = '{raw: 16'h9966, gap: 1'b0, has_word: 1'b1, word: 8'hA5};
    vecs[3] = '{raw: 16'hAAAA, gap: 1'b0, has_word: 1'b1, word: 8'hFF};
    vecs[4] = '{raw: 16'h5555, gap: 1'b1, has_word: 1'b1, word: 8'h00};
    vecs[5] = '{raw: 16'h5AA5, gap: 1'b1, has_word: 1'b1, word: 8'h3C};

    n_reset = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0; out_ready = 1'b1; clear_fail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_health", 32'(health_fail), 0);
    chk("rst_data", 32'(out_data), 0);
    n_reset = 1'b1;
    tick();

    // First word and its latency
    exp_q.push_back(8'h55);
    r = 16'h6666;
    send_bits(r, 15, 1);
    chk("lat_valid_early", 32'(out_valid), 0);
    drive_bit(r[0]);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_level1", 32'(fifo_level), 1);
    chk("lat_data", 32'(out_data), 32'h55);
    tick();
    chk("lat_level0", 32'(fifo_level), 0);
    chk("lat_q", 32'(exp_q.size()), 0);

    foreach (vecs[k]) begin
      if (vecs[k].has_word) exp_q.push_back(vecs[k].word);
      for (int i = 15; i >= 0; i--) begin
        drive_bit(vecs[k].raw[i]);
        if (vecs[k].gap) tick();
      end
      repeat (3) tick();
      chk("vec_drain", 32'(exp_q.size()), 0);
      chk("vec_health", 32'(health_fail), 0);
    end

    // Health trip with two words queued
    out_ready = 1'b0;
    exp_q.push_back(8'h55); send_bits(enc(8'h55), 15, 0);
    exp_q.push_back(8'h55); send_bits(enc(8'h55), 15, 0);
    chk("hf_level2", 32'(fifo_level), 2);
    for (int i = 0; i < 31; i++) drive_bit(1'b1);
    chk("hf_before", 32'(health_fail), 0);
    chk("hf_level_before", 32'(fifo_level), 2);
    drive_bit(1'b1);
    chk("hf_trip", 32'(health_fail), 1);
    chk("hf_flush", 32'(fifo_level), 0);
    chk("hf_valid", 32'(out_valid), 0);
    exp_q.delete();
    out_ready = 1'b1;
    send_bits(enc(8'h55), 15, 0);
    repeat (2) tick();
    chk("hf_ignored_level", 32'(fifo_level), 0);
    chk("hf_sticky", 32'(health_fail), 1);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("hf_cleared", 32'(health_fail), 0);
    exp_q.push_back(8'h55);
    r = enc(8'h55);
    send_bits(r, 15, 8);
    clear_fail = 1'b1;
    drive_bit(r[7]);
    clear_fail = 1'b0;
    send_bits(r, 6, 0);
    drain("hf_resume");
    chk("hf_after", 32'(health_fail), 0);

    // Overflow on the fifth word
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(8'hA5);
      send_bits(16'h9966, 15, 0);
    end
    chk("ov_level4", 32'(fifo_level), 4);
    chk("ov_none_yet", 32'(overflow), 0);
    send_bits(16'h9966, 15, 0);
    chk("ov_pulse", 32'(overflow), 1);
    chk("ov_level_held", 32'(fifo_level), 4);
    tick();
    chk("ov_one_cycle", 32'(overflow), 0);
    out_ready = 1'b1;
    drain("ov_drain");

    // Full FIFO: word completes in the same cycle as a pop
    out_ready = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      exp_q.push_back(8'(n));
      send_bits(enc(8'(n)), 15, 0);
    end
    chk("fp_level4", 32'(fifo_level), 4);
    exp_q.push_back(8'h05);
    r = enc(8'h05);
    send_bits(r, 15, 1);
    out_ready = 1'b1;
    drive_bit(r[0]);
    out_ready = 1'b0;
    chk("fp_level_same", 32'(fifo_level), 4);
    chk("fp_no_overflow", 32'(overflow), 0);
    tick();
    out_ready = 1'b1;
    drain("fp_drain");

    // Reset after five emitted bits
    send_bits(enc(8'h55), 15, 6);
    n_reset = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_level", 32'(fifo_level), 0);
    chk("mr_overflow", 32'(overflow), 0);
    chk("mr_health", 32'(health_fail), 0);
    chk("mr_data", 32'(out_data), 0);
    repeat (2) tick();
    n_reset = 1'b1;
    exp_q.push_back(8'h55);
    send_bits(enc(8'h55), 15, 0);
    drain("mr_word");
    repeat (4) tick();
    chk("mr_no_extra", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
